// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch/decode fields, register-file read ports, forwarding
// sources, pipeline control and the decode/execute register outputs.
interface decode_stage_if #(parameter int WIDTH = 64);
    logic [2:0]       D_stat;
    logic [3:0]       D_icode, D_ifun, D_rA, D_rB;
    logic [WIDTH-1:0] D_valC, D_valP;

    logic [3:0]       rf_readRegA, rf_readRegB;
    logic [WIDTH-1:0] rf_readDataA, rf_readDataB;

    logic [3:0]       e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [WIDTH-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;

    logic [3:0]       E_icode_in, E_dstM_in;
    logic             ext_bubble;
    logic             load_use_stall;

    logic [2:0]       E_stat;
    logic [3:0]       E_icode, E_ifun;
    logic [WIDTH-1:0] E_valC, E_valA, E_valB;
    logic [3:0]       E_dstE, E_dstM, E_srcA, E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output rf_readDataA, rf_readDataB,
        output e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        output e_valE, M_valE, m_valM, W_valE, W_valM,
        output E_icode_in, E_dstM_in, ext_bubble,
        input  rf_readRegA, rf_readRegB, load_use_stall,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  rf_readDataA, rf_readDataB,
        input  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        input  e_valE, M_valE, m_valM, W_valE, W_valM,
        input  E_icode_in, E_dstM_in, ext_bubble,
        output rf_readRegA, rf_readRegB, load_use_stall,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register ID decode, operand forwarding, load-use
// detection and the decode/execute pipeline register.
module decode_stage #(
    parameter int         WIDTH = 64,
    parameter logic [3:0] RSP   = 4'h4,
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic           clock,
    input logic           reset,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic [3:0]       ifun;
        logic [WIDTH-1:0] valC;
        logic [WIDTH-1:0] valA;
        logic [WIDTH-1:0] valB;
        logic [3:0]       dstE;
        logic [3:0]       dstM;
        logic [3:0]       srcA;
        logic [3:0]       srcB;
    } deRegT;

    localparam deRegT BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                                 valC: '0, valA: '0, valB: '0,
                                 dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

    logic [3:0]       srcA, srcB, dstE, dstM;
    logic [WIDTH-1:0] valA, valB;
    logic             stall;
    deRegT            decoded, deReg;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (bus.D_icode)
            4'h2: begin srcA = bus.D_rA; dstE = bus.D_rB; end
            4'h3: dstE = bus.D_rB;
            4'h4: begin srcA = bus.D_rA; srcB = bus.D_rB; end
            4'h5: begin srcB = bus.D_rB; dstM = bus.D_rA; end
            4'h6: begin srcA = bus.D_rA; srcB = bus.D_rB; dstE = bus.D_rB; end
            4'h8: begin srcB = RSP; dstE = RSP; end
            4'h9: begin srcA = RSP; srcB = RSP; dstE = RSP; end
            4'hA: begin srcA = bus.D_rA; srcB = RSP; dstE = RSP; end
            4'hB: begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = bus.D_rA; end
            default: ;
        endcase
    end

    // Nearest producer wins; W must be forwarded because the register file
    // writes on the same edge and its read data lags by a cycle.
    function automatic logic [WIDTH-1:0] fwd(input logic [3:0] src,
                                             input logic [WIDTH-1:0] rfData);
        if (src == RNONE)           return rfData;
        else if (src == bus.e_dstE) return bus.e_valE;
        else if (src == bus.M_dstM) return bus.m_valM;
        else if (src == bus.M_dstE) return bus.M_valE;
        else if (src == bus.W_dstM) return bus.W_valM;
        else if (src == bus.W_dstE) return bus.W_valE;
        else                        return rfData;
    endfunction

    always_comb begin
        valA = fwd(srcA, bus.rf_readDataA);
        if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) valA = bus.D_valP;
        valB = fwd(srcB, bus.rf_readDataB);
    end

    assign stall = (bus.E_icode_in == 4'h5 || bus.E_icode_in == 4'hB) &&
                   (bus.E_dstM_in != RNONE) &&
                   (bus.E_dstM_in == srcA || bus.E_dstM_in == srcB);

    assign decoded = '{stat: bus.D_stat, icode: bus.D_icode, ifun: bus.D_ifun,
                       valC: bus.D_valC, valA: valA, valB: valB,
                       dstE: dstE, dstM: dstM, srcA: srcA, srcB: srcB};

    // A stalled instruction is simply re-decoded next cycle from the held F/D register.
    always_ff @(posedge clock) begin
        if (reset || stall || bus.ext_bubble) deReg <= BUBBLE;
        else                                  deReg <= decoded;
    end

    assign bus.rf_readRegA    = srcA;
    assign bus.rf_readRegB    = srcB;
    assign bus.load_use_stall = stall;
    assign bus.E_stat         = deReg.stat;
    assign bus.E_icode        = deReg.icode;
    assign bus.E_ifun         = deReg.ifun;
    assign bus.E_valC         = deReg.valC;
    assign bus.E_valA         = deReg.valA;
    assign bus.E_valB         = deReg.valB;
    assign bus.E_dstE         = deReg.dstE;
    assign bus.E_dstM         = deReg.dstM;
    assign bus.E_srcA         = deReg.srcA;
    assign bus.E_srcB         = deReg.srcB;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against a table-driven reference of the Y86-64 decode rules.
module tb_decode_stage;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } eT;

    localparam eT BUBBLE = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                             valC: 64'd0, valA: 64'd0, valB: 64'd0,
                             dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] regs [16];
    int          nVec = 0;
    int          nMis = 0;

    decode_stage_if #(.WIDTH(64)) bus();
    decode_stage dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Register file model: reads of RNONE return zero.
    always_comb begin
        bus.rf_readDataA = (bus.rf_readRegA == RNONE) ? 64'd0 : regs[bus.rf_readRegA];
        bus.rf_readDataB = (bus.rf_readRegB == RNONE) ? 64'd0 : regs[bus.rf_readRegB];
    end

    function automatic eT actualE();
        return eT'({bus.E_stat, bus.E_icode, bus.E_ifun, bus.E_valC, bus.E_valA,
                    bus.E_valB, bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB});
    endfunction

    function automatic logic [63:0] opnd(input logic [3:0] src);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        d = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        v = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        if (src == RNONE) return 64'd0;
        for (int i = 0; i < 5; i++) if (d[i] == src) return v[i];
        return regs[src];
    endfunction

    function automatic eT model();
        eT r;
        logic [3:0] ic;
        ic      = bus.D_icode;
        r.stat  = bus.D_stat;
        r.icode = ic;
        r.ifun  = bus.D_ifun;
        r.valC  = bus.D_valC;
        r.srcA  = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? bus.D_rA :
                  (ic inside {4'h9, 4'hB}) ? RSP : RNONE;
        r.srcB  = (ic inside {4'h4, 4'h5, 4'h6}) ? bus.D_rB :
                  (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
        r.dstE  = (ic inside {4'h2, 4'h3, 4'h6}) ? bus.D_rB :
                  (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
        r.dstM  = (ic inside {4'h5, 4'hB}) ? bus.D_rA : RNONE;
        r.valA  = (ic inside {4'h7, 4'h8}) ? bus.D_valP : opnd(r.srcA);
        r.valB  = opnd(r.srcB);
        return r;
    endfunction

    function automatic logic modelStall();
        eT m;
        m = model();
        return (bus.E_icode_in inside {4'h5, 4'hB}) && bus.E_dstM_in != RNONE &&
               (bus.E_dstM_in == m.srcA || bus.E_dstM_in == m.srcB);
    endfunction

    function automatic eT expectNext();
        return (reset || modelStall() || bus.ext_bubble) ? BUBBLE : model();
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.D_stat = 3'd1; bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
        bus.D_rA = RNONE; bus.D_rB = RNONE; bus.D_valC = '0; bus.D_valP = '0;
        bus.e_dstE = RNONE; bus.M_dstE = RNONE; bus.M_dstM = RNONE;
        bus.W_dstE = RNONE; bus.W_dstM = RNONE;
        bus.e_valE = '0; bus.M_valE = '0; bus.m_valM = '0; bus.W_valE = '0; bus.W_valM = '0;
        bus.E_icode_in = 4'h1; bus.E_dstM_in = RNONE; bus.ext_bubble = 1'b0;
    endtask

    task automatic test_reset();
        eT got;
        idle();
        reset = 1'b1;
        bus.D_icode = 4'h6; bus.D_rA = 4'h1; bus.D_rB = 4'h2;
        repeat (2) @(posedge clock);
        #1;
        got = actualE();
        nVec++;
        if (got !== BUBBLE) begin nMis++; $display("FAIL reset got %h want %h", got, BUBBLE); end
        reset = 1'b0;
    endtask

    task automatic test_opq();
        eT exp, got;
        idle();
        regs[1] = 64'd5; regs[2] = 64'd7;
        bus.D_icode = 4'h6; bus.D_rA = 4'h1; bus.D_rB = 4'h2;
        exp = expectNext();
        tick();
        got = actualE();
        nVec += 5;
        if (got.valA !== 64'd5) begin nMis++; $display("FAIL opq_valA got %h want 5", got.valA); end
        if (got.valB !== 64'd7) begin nMis++; $display("FAIL opq_valB got %h want 7", got.valB); end
        if (got.dstE !== 4'h2)  begin nMis++; $display("FAIL opq_dstE got %h want 2", got.dstE); end
        if (got.srcA !== 4'h1)  begin nMis++; $display("FAIL opq_srcA got %h want 1", got.srcA); end
        if (got !== exp)        begin nMis++; $display("FAIL opq_all got %h want %h", got, exp); end
    endtask

    task automatic test_forwarding();
        logic [63:0] want [6];
        want = '{64'hAA, 64'hBB, 64'hCC, 64'hEE, 64'h11, 64'hDD};
        idle();
        regs[3] = 64'hDD;
        bus.D_icode = 4'h2; bus.D_rA = 4'h3; bus.D_rB = 4'h5;
        bus.e_dstE = 4'h3; bus.e_valE = 64'hAA;
        bus.M_dstE = 4'h3; bus.M_valE = 64'hBB;
        bus.W_dstE = 4'h3; bus.W_valE = 64'hCC;
        bus.m_valM = 64'hEE; bus.W_valM = 64'h11;
        for (int step = 0; step < 6; step++) begin
            case (step)
                1: bus.e_dstE = RNONE;
                2: bus.M_dstE = RNONE;
                3: begin bus.W_dstE = RNONE; bus.M_dstM = 4'h3; bus.W_dstM = 4'h3; end
                4: bus.M_dstM = RNONE;
                5: bus.W_dstM = RNONE;
                default: ;
            endcase
            tick();
            nVec++;
            if (bus.E_valA !== want[step]) begin
                nMis++; $display("FAIL fwd_step%0d got %h want %h", step, bus.E_valA, want[step]);
            end
        end
    endtask

    task automatic test_load_use();
        eT got;
        idle();
        regs[4] = 64'h44;
        bus.E_icode_in = 4'h5; bus.E_dstM_in = 4'h4;
        bus.D_icode = 4'hA; bus.D_rA = 4'h4;
        #1;
        nVec++;
        if (bus.load_use_stall !== 1'b1) begin nMis++; $display("FAIL lu_stall got %b want 1", bus.load_use_stall); end
        tick();
        nVec++;
        if (bus.E_icode !== 4'h1) begin nMis++; $display("FAIL lu_bubble got %h want 1", bus.E_icode); end
        bus.E_icode_in = 4'h1;
        #1;
        nVec++;
        if (bus.load_use_stall !== 1'b0) begin nMis++; $display("FAIL lu_release got %b want 0", bus.load_use_stall); end
        tick();
        got = actualE();
        nVec += 4;
        if (got.icode !== 4'hA)  begin nMis++; $display("FAIL lu_icode got %h want a", got.icode); end
        if (got.srcB !== 4'h4)   begin nMis++; $display("FAIL lu_srcB got %h want 4", got.srcB); end
        if (got.dstE !== 4'h4)   begin nMis++; $display("FAIL lu_dstE got %h want 4", got.dstE); end
        if (got.valA !== 64'h44) begin nMis++; $display("FAIL lu_valA got %h want 44", got.valA); end
        // Hazard and external bubble together: one bubble, stall still visible.
        bus.E_icode_in = 4'hB; bus.E_dstM_in = 4'h4; bus.ext_bubble = 1'b1;
        #1;
        nVec++;
        if (bus.load_use_stall !== 1'b1) begin nMis++; $display("FAIL both_stall got %b want 1", bus.load_use_stall); end
        tick();
        got = actualE();
        nVec++;
        if (got !== BUBBLE) begin nMis++; $display("FAIL both_bubble got %h want %h", got, BUBBLE); end
    endtask

    task automatic test_call();
        eT got;
        idle();
        regs[4] = 64'h1000;
        bus.D_icode = 4'h8; bus.D_valP = 64'h123; bus.D_valC = 64'h400;
        tick();
        got = actualE();
        nVec += 5;
        if (got.valA !== 64'h123)  begin nMis++; $display("FAIL call_valA got %h want 123", got.valA); end
        if (got.valB !== 64'h1000) begin nMis++; $display("FAIL call_valB got %h want 1000", got.valB); end
        if (got.srcB !== 4'h4)     begin nMis++; $display("FAIL call_srcB got %h want 4", got.srcB); end
        if (got.dstE !== 4'h4)     begin nMis++; $display("FAIL call_dstE got %h want 4", got.dstE); end
        if (got.dstM !== RNONE)    begin nMis++; $display("FAIL call_dstM got %h want f", got.dstM); end
    endtask

    task automatic test_bubble_reset();
        eT got;
        idle();
        bus.D_icode = 4'h3; bus.D_rB = 4'h5; bus.D_valC = 64'h77; bus.D_stat = 3'd4;
        bus.ext_bubble = 1'b1;
        tick();
        nVec++;
        if (bus.E_icode !== 4'h1) begin nMis++; $display("FAIL ext_bubble got %h want 1", bus.E_icode); end
        bus.ext_bubble = 1'b0;
        tick();
        nVec += 3;
        if (bus.E_icode !== 4'h3) begin nMis++; $display("FAIL irmov_icode got %h want 3", bus.E_icode); end
        if (bus.E_valC !== 64'h77) begin nMis++; $display("FAIL irmov_valC got %h want 77", bus.E_valC); end
        if (bus.E_stat !== 3'd4)  begin nMis++; $display("FAIL stat_pass got %h want 4", bus.E_stat); end
        reset = 1'b1;
        tick();
        got = actualE();
        nVec++;
        if (got !== BUBBLE) begin nMis++; $display("FAIL mid_reset got %h want %h", got, BUBBLE); end
        reset = 1'b0;
    endtask

    function automatic logic [3:0] rndReg();
        return ($urandom_range(0, 5) == 5) ? RNONE : 4'($urandom_range(0, 4));
    endfunction

    task automatic test_random();
        eT exp, got, m;
        logic stallExp;
        for (int r = 0; r < 16; r++) regs[r] = {$urandom, $urandom};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) regs[$urandom_range(0, 14)] = {$urandom, $urandom};
            reset = ($urandom_range(0, 49) == 0);
            bus.D_stat = 3'($urandom); bus.D_icode = 4'($urandom_range(0, 11));
            bus.D_ifun = 4'($urandom); bus.D_rA = rndReg(); bus.D_rB = rndReg();
            bus.D_valC = {$urandom, $urandom}; bus.D_valP = {$urandom, $urandom};
            bus.e_dstE = rndReg(); bus.M_dstE = rndReg(); bus.M_dstM = rndReg();
            bus.W_dstE = rndReg(); bus.W_dstM = rndReg();
            bus.e_valE = {$urandom, $urandom}; bus.M_valE = {$urandom, $urandom};
            bus.m_valM = {$urandom, $urandom}; bus.W_valE = {$urandom, $urandom};
            bus.W_valM = {$urandom, $urandom};
            bus.E_icode_in = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h5 : 4'hB)
                                                         : 4'($urandom_range(0, 11));
            bus.E_dstM_in = rndReg();
            bus.ext_bubble = ($urandom_range(0, 9) == 0);
            #1;
            m = model();
            stallExp = modelStall();
            exp = expectNext();
            nVec += 2;
            if (bus.load_use_stall !== stallExp) begin
                nMis++; $display("FAIL rnd%0d_stall got %b want %b", n, bus.load_use_stall, stallExp);
            end
            if ({bus.rf_readRegA, bus.rf_readRegB} !== {m.srcA, m.srcB}) begin
                nMis++; $display("FAIL rnd%0d_rfaddr got %h%h want %h%h", n,
                                 bus.rf_readRegA, bus.rf_readRegB, m.srcA, m.srcB);
            end
            tick();
            got = actualE();
            nVec++;
            if (got !== exp) begin nMis++; $display("FAIL rnd%0d_E got %h want %h", n, got, exp); end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) regs[r] = 64'd0;
        test_reset();
        test_opq();
        test_forwarding();
        test_load_use();
        test_call();
        test_bubble_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
